// File: rtl/turn_sequencer.sv
// turn_sequencer: gomoku game controller; validates a placement, writes the stone,
// launches the win checker and turns its verdict into win, draw or next turn.
module turn_sequencer #(
    parameter int BOARD_CELLS   = 225,
    parameter int MEM_LATENCY   = 1,
    parameter int CHECK_TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       place,
    input  logic [7:0] cursor,
    output logic       mem_sel,
    output logic [7:0] mem_addr,
    output logic [1:0] mem_wdata,
    output logic       mem_we,
    input  logic [1:0] mem_rdata,
    output logic       check_go,
    output logic [7:0] check_pointer,
    output logic [1:0] check_chess,
    input  logic       check_success,
    input  logic       check_fail,
    output logic [1:0] current_player,
    output logic [1:0] winner,
    output logic       game_over,
    output logic       busy,
    output logic       reject,
    output logic [8:0] move_count,
    output logic       check_err
);
    localparam int TW = $clog2(CHECK_TIMEOUT + 1);
    localparam int LW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_JUDGE, S_WRITE, S_LAUNCH, S_CHECK, S_OVER} state_t;

    state_t         r_state, w_next;
    logic           r_place_d;
    logic [7:0]     r_pos;
    logic [LW-1:0]  r_lat;
    logic [TW-1:0]  r_to;
    logic [1:0]     r_player, r_winner, r_chess;
    logic [7:0]     r_pointer;
    logic [8:0]     r_count;
    logic           r_over, r_reject, r_err;
    logic           w_edge, w_occupied, w_timeout, w_fail, w_draw;
    logic [8:0]     w_cnt_inc;

    assign w_edge     = place & ~r_place_d;
    assign w_occupied = mem_rdata != 2'b00;
    assign w_timeout  = r_to == TW'(CHECK_TIMEOUT - 1);
    assign w_fail     = check_fail | w_timeout;
    assign w_cnt_inc  = (r_count == 9'd511) ? r_count : r_count + 9'd1;
    assign w_draw     = w_cnt_inc == 9'(BOARD_CELLS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = w_edge ? S_READ : S_IDLE;
            S_READ:   w_next = (r_lat == LW'(MEM_LATENCY - 1)) ? S_JUDGE : S_READ;
            S_JUDGE:  w_next = w_occupied ? S_IDLE : S_WRITE;
            S_WRITE:  w_next = S_LAUNCH;
            S_LAUNCH: w_next = S_CHECK;
            S_CHECK:  w_next = (check_success || (w_fail && w_draw)) ? S_OVER : (w_fail ? S_IDLE : S_CHECK);
            default:  w_next = r_state;
        endcase
    end

    // Memory and checker strobes decode from the state register only, so no
    // checker input can reach the memory port combinationally.
    always_comb begin
        mem_sel  = !(r_state == S_LAUNCH || r_state == S_CHECK);
        mem_we   = r_state == S_WRITE;
        check_go = r_state == S_LAUNCH;
        busy     = !(r_state == S_IDLE || r_state == S_OVER);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_place_d <= 1'b1;
            r_pos     <= '0;
            r_lat     <= '0;
            r_to      <= '0;
            r_player  <= 2'b01;
            r_winner  <= 2'b00;
            r_chess   <= 2'b00;
            r_pointer <= '0;
            r_count   <= '0;
            r_over    <= 1'b0;
            r_reject  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_place_d <= place;
            r_reject  <= (r_state == S_JUDGE) && w_occupied;
            r_lat     <= (r_state == S_READ) ? r_lat + LW'(1) : '0;
            if (r_state == S_IDLE && w_edge) r_pos <= cursor;
            if (r_state == S_WRITE) begin
                r_pointer <= r_pos;
                r_chess   <= r_player;
            end
            if (r_state == S_LAUNCH) r_to <= '0;
            if (r_state == S_CHECK) begin
                r_to <= r_to + TW'(1);
                if (check_success) begin
                    r_count  <= w_cnt_inc;
                    r_winner <= r_player;
                    r_over   <= 1'b1;
                end else if (w_fail) begin
                    r_count <= w_cnt_inc;
                    if (!check_fail) r_err <= 1'b1;
                    if (w_draw) begin
                        r_winner <= 2'b11;
                        r_over   <= 1'b1;
                    end else begin
                        r_player <= ~r_player;
                    end
                end
            end
        end
    end

    assign mem_addr       = r_pos;
    assign mem_wdata      = r_player;
    assign check_pointer  = r_pointer;
    assign check_chess    = r_chess;
    assign current_player = r_player;
    assign winner         = r_winner;
    assign game_over      = r_over;
    assign reject         = r_reject;
    assign move_count     = r_count;
    assign check_err      = r_err;
endmodule

// File: tb/tb_turn_sequencer.sv
// tb_turn_sequencer: directed bench with a 1-cycle board memory model and a hand-driven
// win checker; a 3-cell board makes the draw reachable.
module tb_turn_sequencer;
    logic       clk = 0, reset = 1, place = 0;
    logic [7:0] cursor = 0;
    logic       mem_sel, mem_we, check_go, game_over, busy, reject, check_err;
    logic [7:0] mem_addr, check_pointer;
    logic [1:0] mem_wdata, mem_rdata, check_chess, current_player, winner;
    logic       check_success = 0, check_fail = 0;
    logic [8:0] move_count;
    logic [1:0] board [256];
    int n_chk = 0, n_err = 0;
    int n_we = 0, n_go = 0, n_rej = 0;
    logic [7:0] we_addr;
    logic [1:0] we_data;
    int base_we, base_go, cyc;
    bit ok;

    turn_sequencer #(.BOARD_CELLS(3), .MEM_LATENCY(1), .CHECK_TIMEOUT(1023)) dut (
        .clk(clk), .reset(reset), .place(place), .cursor(cursor),
        .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .check_go(check_go), .check_pointer(check_pointer),
        .check_chess(check_chess), .check_success(check_success), .check_fail(check_fail),
        .current_player(current_player), .winner(winner), .game_over(game_over),
        .busy(busy), .reject(reject), .move_count(move_count), .check_err(check_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_sel && mem_we) board[mem_addr] <= mem_wdata;
        mem_rdata <= board[mem_addr];
    end

    always @(negedge clk) begin
        if (mem_we) begin
            n_we    <= n_we + 1;
            we_addr <= mem_addr;
            we_data <= mem_wdata;
        end
        if (check_go) n_go <= n_go + 1;
        if (reject) n_rej <= n_rej + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [7:0] pos);
        cursor = pos;
        place  = 1;
        tick(1);
        place  = 0;
        tick(1);
    endtask

    task automatic wait_go(output bit found);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (check_go) found = 1;
            else tick(1);
        end
        chk("go_seen", found, 1);
    endtask

    task automatic answer(input int dly, input logic s, input logic f);
        tick(dly);
        check_success = s;
        check_fail    = f;
        tick(1);
        check_success = 0;
        check_fail    = 0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) board[i] = 2'b00;
        mem_rdata = 2'b00;
        tick(2);
        chk("rst_player", current_player, 2'b01);
        chk("rst_winner", winner, 2'b00);
        chk("rst_over", game_over, 0);
        chk("rst_count", move_count, 0);
        chk("rst_sel", mem_sel, 1);
        chk("rst_busy", busy, 0);
        reset = 0;
        tick(2);

        // move 1: black at 0x12, checker fails 5 cycles after go
        press(8'h12);
        wait_go(ok);
        chk("m1_ptr", check_pointer, 8'h12);
        chk("m1_chess", check_chess, 2'b01);
        chk("m1_sel_launch", mem_sel, 0);
        tick(3);
        chk("m1_busy_check", busy, 1);
        chk("m1_ptr_held", check_pointer, 8'h12);
        answer(2, 0, 1);
        tick(1);
        chk("m1_we_cnt", n_we, 1);
        chk("m1_we_addr", we_addr, 8'h12);
        chk("m1_we_data", we_data, 2'b01);
        chk("m1_go_cnt", n_go, 1);
        chk("m1_player", current_player, 2'b10);
        chk("m1_count", move_count, 1);
        chk("m1_busy", busy, 0);
        chk("m1_sel", mem_sel, 1);

        // occupied cell is rejected with no write and no launch
        press(8'h12);
        tick(4);
        chk("rej_cnt", n_rej, 1);
        chk("rej_we", n_we, 1);
        chk("rej_go", n_go, 1);
        chk("rej_player", current_player, 2'b10);
        chk("rej_busy", busy, 0);

        // move 2: success and fail together, success wins
        press(8'h34);
        wait_go(ok);
        chk("m2_ptr", check_pointer, 8'h34);
        chk("m2_chess", check_chess, 2'b10);
        answer(2, 1, 1);
        tick(1);
        chk("m2_winner", winner, 2'b10);
        chk("m2_over", game_over, 1);
        chk("m2_count", move_count, 2);
        chk("m2_busy", busy, 0);
        press(8'h56);
        tick(6);
        chk("over_we", n_we, 2);
        chk("over_go", n_go, 2);
        chk("over_sel", mem_sel, 1);
        chk("over_player", current_player, 2'b10);

        // key held through reset release must not start a move
        place = 1;
        reset = 1;
        tick(2);
        reset = 0;
        tick(4);
        chk("held_busy", busy, 0);
        chk("held_we", n_we, 2);
        chk("held_over", game_over, 0);
        chk("held_player", current_player, 2'b01);
        place = 0;
        tick(2);

        // draw on a 3-cell board
        press(8'h01);
        wait_go(ok);
        answer(1, 0, 1);
        chk("d1_player", current_player, 2'b10);
        press(8'h02);
        wait_go(ok);
        answer(1, 0, 1);
        chk("d2_player", current_player, 2'b01);
        press(8'h03);
        wait_go(ok);
        answer(1, 0, 1);
        tick(1);
        chk("draw_winner", winner, 2'b11);
        chk("draw_over", game_over, 1);
        chk("draw_count", move_count, 3);
        chk("draw_player", current_player, 2'b01);
        chk("draw_err", check_err, 0);

        // checker never answers
        reset = 1;
        tick(1);
        reset = 0;
        tick(2);
        press(8'h40);
        wait_go(ok);
        cyc = 0;
        while (busy && cyc < 1100) begin
            tick(1);
            cyc++;
            if (cyc == 1022) chk("to_err_early", check_err, 0);
        end
        chk("to_cycles", cyc, 1024);
        chk("to_err", check_err, 1);
        chk("to_player", current_player, 2'b10);
        chk("to_sel", mem_sel, 1);
        chk("to_count", move_count, 1);

        // place edge while busy is discarded, not queued
        base_we = n_we;
        base_go = n_go;
        press(8'h50);
        press(8'h60);
        wait_go(ok);
        chk("busy_ptr", check_pointer, 8'h50);
        answer(1, 0, 1);
        tick(8);
        chk("busy_go", n_go - base_go, 1);
        chk("busy_we", n_we - base_we, 1);
        chk("busy_we_addr", we_addr, 8'h50);
        chk("busy_player", current_player, 2'b01);

        // asynchronous reset in the middle of CHECK
        press(8'h70);
        wait_go(ok);
        tick(2);
        reset = 1;
        #1;
        chk("mid_sel", mem_sel, 1);
        chk("mid_busy", busy, 0);
        chk("mid_count", move_count, 0);
        chk("mid_err", check_err, 0);
        chk("mid_player", current_player, 2'b01);
        chk("mid_board", board[8'h70], 2'b01);
        tick(1);
        reset = 0;
        tick(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/turn_sequencer.md
Name: turn_sequencer

Overview:
- Game-level controller for the gomoku board.
- Accepts a player's placement request and checks that the target cell is empty.
- Writes the stone into the board memory, then launches the win checker and hands it the board memory port.
- Interprets the checker's success/fail result to declare a winner, declare a draw, or pass the turn to the other player.

Parameters:
BOARD_CELLS, 225, number of playable cells; the game is a draw when this many stones are placed with no win
MEM_LATENCY, 1, board memory read latency in cycles (1..3)
CHECK_TIMEOUT, 1023, maximum cycles to wait in CHECK for a checker result

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high
place  input  1  placement key, debounced level; action on its rising edge
cursor  input  8  board position selected by the player
mem_sel  output  1  1 = this block drives the board memory port, 0 = win checker drives it
mem_addr  output  8  board memory address
mem_wdata  output  2  chess code to write (00 empty, 01 black, 10 white)
mem_we  output  1  board memory write enable
mem_rdata  input  2  board memory read data
check_go  output  1  one-cycle start pulse to the win checker
check_pointer  output  8  position of the just-placed stone
check_chess  output  2  colour of the just-placed stone
check_success  input  1  checker found five in a row
check_fail  input  1  checker found no line
current_player  output  2  colour to move (01/10)
winner  output  2  00 none, 01 black, 10 white, 11 draw
game_over  output  1  game finished; further placements ignored
busy  output  1  high in every state except IDLE and OVER
reject  output  1  one-cycle pulse: target cell occupied
move_count  output  9  stones placed this game
check_err  output  1  sticky: a checker timeout occurred

Behaviour:
- Reset values:
  - current_player=01; winner=00; game_over=0; move_count=0; check_err=0.
  - mem_sel=1; mem_we=0; check_go=0; reject=0; busy=0.
  - State=IDLE; internal place_d=1, so a key held through reset does not trigger.
- Edge detect: place_edge = place & ~place_d; place_d is registered every cycle.
- States: IDLE, READ, JUDGE, WRITE, LAUNCH, CHECK, OVER.
- IDLE: mem_sel=1. On place_edge, latch cursor into pos_r and go to READ. In all other states place_edge is discarded, never queued.
- READ: mem_addr=pos_r. Stay MEM_LATENCY cycles, then go to JUDGE.
- JUDGE: sample mem_rdata.
  - Non-zero: reject=1 for this cycle; next state IDLE; no other state changes.
  - Zero: go to WRITE.
- WRITE: exactly one cycle with mem_we=1, mem_addr=pos_r, mem_wdata=current_player; then LAUNCH.
- LAUNCH: mem_sel=0; check_go=1 for one cycle; clear timeout counter; then CHECK.
- check_pointer=pos_r and check_chess=current_player are registered and held stable from LAUNCH until CHECK exits.
- CHECK: mem_sel=0; mem_we=0. Timeout counter increments each cycle. Evaluated each cycle:
  - check_success (priority over check_fail if both high): move_count+1; winner=current_player; game_over=1; go to OVER.
  - check_fail: move_count+1. If the new count equals BOARD_CELLS: winner=11, game_over=1, go to OVER. Otherwise toggle current_player (01<->10) and go to IDLE.
  - Counter reaches CHECK_TIMEOUT with no result: check_err=1, then handle exactly as check_fail in that cycle.
- OVER: mem_sel=1; busy=0. Holds all outputs until reset.
- mem_sel returns to 1 in the cycle after CHECK exits.
- All outputs are registered, or decoded only from the state register. No combinational path from check_* to mem_*.
- move_count saturates at 511; it cannot exceed BOARD_CELLS in legal play.
- Reset mid-operation: immediate return to reset values. A board write already performed persists; board clearing is out of scope.

Test Plan:
- Reset, cursor=8'h12, pulse place, mem_rdata=00, checker answers fail 5 cycles after go -> one mem_we at addr 12 data 01; one check_go with check_pointer=12, check_chess=01; then current_player=10, move_count=1, busy=0.
- Place on a cell returning mem_rdata=01 -> reject pulse 1 cycle; no mem_we; no check_go; current_player unchanged.
- Second move: checker asserts success and fail in the same cycle -> winner=10, game_over=1, move_count=2; later place edges produce no memory activity.
- BOARD_CELLS=3, three fail moves -> winner=11, game_over=1, move_count=3.
- Checker never answers -> after 1023 CHECK cycles check_err=1, player toggles, mem_sel returns to 1.
- place held high across reset deassertion -> no action; place pulsed while busy -> ignored; reset asserted during CHECK -> all outputs at reset values next edge.
